// File: rtl/g_function_arbiter_pkg.sv
// Shared types and constants for the G_function core arbiter.
package g_function_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_F = 1'b0,
    GRANT_K = 1'b1
  } grant_t;

  localparam int SEED_G_LAT = 5;
  localparam int CNT_W      = 4;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/g_function_arbiter_if.sv
// Requester and G-core signal bundle; the arbiter uses the slave view.
interface g_function_arbiter_if;

  logic        req_f;
  logic [31:0] data_f;
  logic        ack_f;
  logic        req_k;
  logic [31:0] data_k;
  logic        ack_k;
  logic [31:0] result;
  logic        busy;
  logic [7:0]  g_inp;
  logic        g_enable;
  logic [7:0]  g_outp;

  modport master (
    output req_f, data_f, req_k, data_k, g_outp,
    input  ack_f, ack_k, result, busy, g_inp, g_enable
  );

  modport slave (
    input  req_f, data_f, req_k, data_k, g_outp,
    output ack_f, ack_k, result, busy, g_inp, g_enable
  );

endinterface

// File: rtl/g_function_arbiter_rr.sv
// Two-way round-robin grant; the winner of a tie is whichever port was not served last.
module g_function_arbiter_rr
  import g_function_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   i_req_f,
  input  logic   i_req_k,
  input  logic   i_update,
  input  grant_t i_grant,
  output logic   o_valid,
  output grant_t o_grant
);

  grant_t r_last_grant;

  // Reset to K so that F wins the very first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= GRANT_K;
    end else if (i_update) begin
      r_last_grant <= i_grant;
    end
  end

  always_comb begin
    o_valid = i_req_f | i_req_k;
    o_grant = GRANT_F;
    if (i_req_f && i_req_k) begin
      o_grant = (r_last_grant == GRANT_F) ? GRANT_K : GRANT_F;
    end else if (i_req_k) begin
      o_grant = GRANT_K;
    end
  end

endmodule

// File: rtl/g_function_arbiter.sv
// Shares the byte-serial G_function core between the F-round and key-schedule requesters,
// feeding four bytes LSB first and reassembling the four output bytes G_LAT cycles later.
module g_function_arbiter
  import g_function_arbiter_pkg::*;
#(
  parameter int G_LAT = SEED_G_LAT
) (
  input logic                 clk,
  input logic                 reset_n,
  g_function_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] FEED_END  = CNT_W'(WORD_BYTES);
  localparam logic [CNT_W-1:0] CAP_FIRST = CNT_W'(G_LAT);
  localparam logic [CNT_W-1:0] CAP_LAST  = CNT_W'(G_LAT + WORD_BYTES - 1);

  state_t           r_state;
  grant_t           r_grant;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_in_sr;
  logic [31:0]      r_out_sr;
  logic [31:0]      r_result;
  logic             r_ack_f;
  logic             r_ack_k;
  logic             r_g_enable;
  logic             r_busy;

  logic             w_arb_valid;
  grant_t           w_arb_grant;
  logic             w_done;
  logic             w_feed;
  logic [31:0]      w_grant_word;

  assign w_done       = (r_state == DONE);
  assign w_feed       = (r_state == BUSY) && (r_cnt < FEED_END);
  assign w_grant_word = (w_arb_grant == GRANT_K) ? bus.data_k : bus.data_f;

  g_function_arbiter_rr u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req_f (bus.req_f),
    .i_req_k (bus.req_k),
    .i_update(w_done),
    .i_grant (r_grant),
    .o_valid (w_arb_valid),
    .o_grant (w_arb_grant)
  );

  // Feed and capture windows are independent, so they overlap naturally when G_LAT < 4.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_grant    <= GRANT_F;
      r_cnt      <= '0;
      r_in_sr    <= '0;
      r_out_sr   <= '0;
      r_result   <= '0;
      r_ack_f    <= 1'b0;
      r_ack_k    <= 1'b0;
      r_g_enable <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_ack_f <= 1'b0;
      r_ack_k <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_arb_valid) begin
            r_in_sr    <= w_grant_word;
            r_grant    <= w_arb_grant;
            r_cnt      <= '0;
            r_g_enable <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          if (w_feed) begin
            r_in_sr <= {8'h00, r_in_sr[31:8]};
          end
          if (r_cnt >= CAP_FIRST) begin
            r_out_sr <= {bus.g_outp, r_out_sr[31:8]};
          end
          if (r_cnt == CAP_LAST) begin
            r_g_enable <= 1'b0;
            r_state    <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_result <= r_out_sr;
          r_ack_f  <= (r_grant == GRANT_F);
          r_ack_k  <= (r_grant == GRANT_K);
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.g_inp    = w_feed ? r_in_sr[7:0] : 8'h00;
  assign bus.g_enable = r_g_enable;
  assign bus.busy     = r_busy;
  assign bus.ack_f    = r_ack_f;
  assign bus.ack_k    = r_ack_k;
  assign bus.result   = r_result;

endmodule

// File: tb/tb_g_function_arbiter.sv
// Directed bench: two arbiters (G_LAT 5 and 2), each with an identity core delaying bytes by G_LAT.
module tb_g_function_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  g_function_arbiter_if bus5 ();
  g_function_arbiter_if bus2 ();

  g_function_arbiter #(.G_LAT(5)) dut5 (.clk(clk), .reset_n(reset_n), .bus(bus5));
  g_function_arbiter #(.G_LAT(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

  always #5 clk = ~clk;

  logic [7:0] core5 [0:4];
  logic [7:0] core2 [0:1];

  // Identity core: byte fed at cnt i reappears on g_outp at cnt i + G_LAT.
  always @(posedge clk) begin
    core5[0] <= bus5.g_inp;
    for (int j = 1; j < 5; j++) core5[j] <= core5[j-1];
    core2[0] <= bus2.g_inp;
    core2[1] <= core2[0];
  end

  assign bus5.g_outp = core5[4];
  assign bus2.g_outp = core2[1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus5.req_f = 1'b0; bus5.req_k = 1'b0; bus5.data_f = '0; bus5.data_k = '0;
    bus2.req_f = 1'b0; bus2.req_k = 1'b0; bus2.data_f = '0; bus2.data_k = '0;
    repeat (6) tick();
    checks++;
    if ({bus5.ack_f, bus5.ack_k, bus5.g_enable, bus5.busy} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl5: got %b expected 0000", {bus5.ack_f, bus5.ack_k, bus5.g_enable, bus5.busy});
    end
    checks++;
    if (bus5.g_inp !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_ginp5: got %h expected 00", bus5.g_inp);
    end
    checks++;
    if (bus5.result !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_result5: got %h expected 00000000", bus5.result);
    end
    checks++;
    if ({bus2.ack_f, bus2.ack_k, bus2.g_enable, bus2.busy} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl2: got %b expected 0000", {bus2.ack_f, bus2.ack_k, bus2.g_enable, bus2.busy});
    end
    checks++;
    if ({bus2.g_inp, bus2.result} !== 40'h0) begin
      errors++;
      $display("[TB] FAIL reset_data2: got %h expected 0", {bus2.g_inp, bus2.result});
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_f();
    logic [31:0] word;
    int enCnt, ackAt, kAcks;
    word = 32'h11223344;
    enCnt = 0; ackAt = -1; kAcks = 0;
    bus5.data_f = word;
    bus5.req_f  = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (k <= 4) begin
        checks++;
        if (bus5.g_inp !== ((k < 4) ? word[8*k +: 8] : 8'h00)) begin
          errors++;
          $display("[TB] FAIL single_ginp cnt%0d: got %h expected %h", k, bus5.g_inp,
                   (k < 4) ? word[8*k +: 8] : 8'h00);
        end
      end
      if (k == 9 || k == 10) begin
        checks++;
        if (bus5.busy !== (k == 9)) begin
          errors++;
          $display("[TB] FAIL single_busy k%0d: got %b expected %b", k, bus5.busy, (k == 9));
        end
      end
      if (bus5.g_enable === 1'b1) enCnt++;
      if (bus5.ack_k === 1'b1) kAcks++;
      if (bus5.ack_f === 1'b1) begin
        if (ackAt < 0) ackAt = k;
        checks++;
        if (bus5.result !== word) begin
          errors++;
          $display("[TB] FAIL single_result: got %h expected %h", bus5.result, word);
        end
        bus5.req_f = 1'b0;
      end
    end
    checks++;
    if (enCnt != 9) begin
      errors++;
      $display("[TB] FAIL single_enable_cycles: got %0d expected 9", enCnt);
    end
    checks++;
    if (ackAt != 10) begin
      errors++;
      $display("[TB] FAIL single_ack_latency: got %0d expected 10", ackAt);
    end
    checks++;
    if (kAcks != 0) begin
      errors++;
      $display("[TB] FAIL single_ack_k: got %0d expected 0", kAcks);
    end
    bus5.req_f = 1'b0;
  endtask

  task automatic test_simultaneous();
    int nAck, minGap, runLow;
    logic seenHigh;
    logic who [2];
    logic [31:0] res [2];
    int ackCycle [2];
    nAck = 0; minGap = 99; runLow = 0; seenHigh = 1'b0;
    who[0] = 1'bx; who[1] = 1'bx; res[0] = 'x; res[1] = 'x; ackCycle[0] = -1; ackCycle[1] = -1;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    bus5.data_f = 32'hAAAAAAAA; bus5.data_k = 32'h55555555;
    bus5.req_f  = 1'b1;         bus5.req_k  = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus5.g_enable === 1'b1) begin
        if (seenHigh && runLow > 0 && runLow < minGap) minGap = runLow;
        seenHigh = 1'b1;
        runLow = 0;
      end else if (seenHigh) begin
        runLow++;
      end
      if (bus5.ack_f === 1'b1 || bus5.ack_k === 1'b1) begin
        if (nAck < 2) begin
          who[nAck] = bus5.ack_k;
          res[nAck] = bus5.result;
          ackCycle[nAck] = k;
        end
        nAck++;
        if (bus5.ack_f === 1'b1) bus5.req_f = 1'b0;
        if (bus5.ack_k === 1'b1) bus5.req_k = 1'b0;
      end
    end
    checks++;
    if (nAck != 2) begin
      errors++;
      $display("[TB] FAIL simul_ack_count: got %0d expected 2", nAck);
    end
    checks++;
    if ({who[0], who[1]} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL simul_order (0=F,1=K): got %b%b expected 01", who[0], who[1]);
    end
    checks++;
    if (res[0] !== 32'hAAAAAAAA || res[1] !== 32'h55555555) begin
      errors++;
      $display("[TB] FAIL simul_results: got %h %h expected aaaaaaaa 55555555", res[0], res[1]);
    end
    checks++;
    if (ackCycle[0] != 10 || ackCycle[1] != 21) begin
      errors++;
      $display("[TB] FAIL simul_ack_cycles: got %0d %0d expected 10 21", ackCycle[0], ackCycle[1]);
    end
    checks++;
    if (minGap != 2) begin
      errors++;
      $display("[TB] FAIL simul_enable_gap: got %0d expected 2", minGap);
    end
  endtask

  task automatic test_fairness();
    int nAck;
    logic who [4];
    logic [31:0] res [4];
    int ackCycle [4];
    nAck = 0;
    for (int i = 0; i < 4; i++) begin
      who[i] = 1'bx; res[i] = 'x; ackCycle[i] = -1;
    end
    tick();
    bus5.data_f = 32'h13579BDF; bus5.data_k = 32'h2468ACE0;
    bus5.req_f  = 1'b1;         bus5.req_k  = 1'b1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (bus5.ack_f === 1'b1 || bus5.ack_k === 1'b1) begin
        if (nAck < 4) begin
          who[nAck] = bus5.ack_k;
          res[nAck] = bus5.result;
          ackCycle[nAck] = k;
        end
        nAck++;
        if (nAck == 4) begin
          bus5.req_f = 1'b0;
          bus5.req_k = 1'b0;
        end
      end
    end
    checks++;
    if (nAck != 4) begin
      errors++;
      $display("[TB] FAIL fair_ack_count: got %0d expected 4", nAck);
    end
    checks++;
    if ({who[0], who[1], who[2], who[3]} !== 4'b0101) begin
      errors++;
      $display("[TB] FAIL fair_order (0=F,1=K): got %b%b%b%b expected 0101", who[0], who[1], who[2], who[3]);
    end
    checks++;
    if (res[0] !== 32'h13579BDF || res[1] !== 32'h2468ACE0 ||
        res[2] !== 32'h13579BDF || res[3] !== 32'h2468ACE0) begin
      errors++;
      $display("[TB] FAIL fair_results: got %h %h %h %h expected 13579bdf 2468ace0 13579bdf 2468ace0",
               res[0], res[1], res[2], res[3]);
    end
    checks++;
    if (ackCycle[0] != 10 || ackCycle[1] != 21 || ackCycle[2] != 32 || ackCycle[3] != 43) begin
      errors++;
      $display("[TB] FAIL fair_ack_cycles: got %0d %0d %0d %0d expected 10 21 32 43",
               ackCycle[0], ackCycle[1], ackCycle[2], ackCycle[3]);
    end
  endtask

  task automatic test_glat2_overlap();
    logic [31:0] word;
    int enCnt, ackAt, fAcks;
    word = 32'hDEADBEEF;
    enCnt = 0; ackAt = -1; fAcks = 0;
    tick();
    bus2.data_k = word;
    bus2.req_k  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k < 4) begin
        checks++;
        if (bus2.g_inp !== word[8*k +: 8]) begin
          errors++;
          $display("[TB] FAIL lat2_ginp cnt%0d: got %h expected %h", k, bus2.g_inp, word[8*k +: 8]);
        end
      end
      if (bus2.g_enable === 1'b1) enCnt++;
      if (bus2.ack_f === 1'b1) fAcks++;
      if (bus2.ack_k === 1'b1) begin
        if (ackAt < 0) ackAt = k;
        checks++;
        if (bus2.result !== word) begin
          errors++;
          $display("[TB] FAIL lat2_result: got %h expected %h", bus2.result, word);
        end
        bus2.req_k = 1'b0;
      end
    end
    checks++;
    if (ackAt != 7) begin
      errors++;
      $display("[TB] FAIL lat2_ack_latency: got %0d expected 7", ackAt);
    end
    checks++;
    if (enCnt != 6 || fAcks != 0) begin
      errors++;
      $display("[TB] FAIL lat2_enable_and_ackf: got %0d %0d expected 6 0", enCnt, fAcks);
    end
    bus2.req_k = 1'b0;
  endtask

  task automatic test_reset_midop();
    int ackAt, fAcks;
    ackAt = -1; fAcks = 0;
    tick();
    bus5.data_f = 32'h12345678;
    bus5.req_f  = 1'b1;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus5.ack_f, bus5.ack_k, bus5.g_enable, bus5.busy} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midop_ctrl: got %b expected 0000", {bus5.ack_f, bus5.ack_k, bus5.g_enable, bus5.busy});
    end
    checks++;
    if ({bus5.result, bus5.g_inp} !== 40'h0) begin
      errors++;
      $display("[TB] FAIL midop_data: got %h expected 0", {bus5.result, bus5.g_inp});
    end
    bus5.req_f = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    bus5.data_k = 32'h01020304;
    bus5.req_k  = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (bus5.ack_f === 1'b1) fAcks++;
      if (bus5.ack_k === 1'b1) begin
        if (ackAt < 0) ackAt = k;
        checks++;
        if (bus5.result !== 32'h01020304) begin
          errors++;
          $display("[TB] FAIL midop_new_result: got %h expected 01020304", bus5.result);
        end
        bus5.req_k = 1'b0;
      end
    end
    checks++;
    if (ackAt != 10 || fAcks != 0) begin
      errors++;
      $display("[TB] FAIL midop_new_ack: got k%0d fAcks %0d expected k10 fAcks 0", ackAt, fAcks);
    end
    bus5.req_k = 1'b0;
  endtask

  task automatic test_late_request();
    int fAt, kAt;
    fAt = -1; kAt = -1;
    tick();
    bus5.data_f = 32'hCAFEF00D;
    bus5.req_f  = 1'b1;
    for (int k = 0; k < 26; k++) begin
      tick();
      if (k == 3) begin
        bus5.data_k = 32'h0BADC0DE;
        bus5.req_k  = 1'b1;
      end
      if (k == 11) begin
        checks++;
        if (bus5.busy !== 1'b1 || bus5.g_inp !== 8'hDE) begin
          errors++;
          $display("[TB] FAIL late_grant: got busy %b ginp %h expected busy 1 ginp de", bus5.busy, bus5.g_inp);
        end
      end
      if (bus5.ack_f === 1'b1) begin
        if (fAt < 0) fAt = k;
        checks++;
        if (bus5.result !== 32'hCAFEF00D) begin
          errors++;
          $display("[TB] FAIL late_result_f: got %h expected cafef00d", bus5.result);
        end
        bus5.req_f = 1'b0;
      end
      if (bus5.ack_k === 1'b1) begin
        if (kAt < 0) kAt = k;
        checks++;
        if (bus5.result !== 32'h0BADC0DE) begin
          errors++;
          $display("[TB] FAIL late_result_k: got %h expected 0badc0de", bus5.result);
        end
        bus5.req_k = 1'b0;
      end
    end
    checks++;
    if (fAt != 10 || kAt != 21) begin
      errors++;
      $display("[TB] FAIL late_ack_cycles: got %0d %0d expected 10 21", fAt, kAt);
    end
    bus5.req_f = 1'b0;
    bus5.req_k = 1'b0;
  endtask

  initial begin
    $display("[TB] starting g_function_arbiter bench");
    test_reset();
    test_single_f();
    test_simultaneous();
    test_fairness();
    test_glat2_overlap();
    test_reset_midop();
    test_late_request();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/g_function_arbiter.md
Name: g_function_arbiter

Overview:
- Sequences the 8-bit serialized G_function core and shares it between two 32-bit requesters: the F-function round datapath (port F) and the key-schedule datapath (port K).
- Splits the granted 32-bit word into four bytes and feeds the core one byte per cycle with enable held high.
- Collects the four output bytes after a fixed core latency and returns the reassembled 32-bit result with a one-cycle acknowledge to the granted requester.
- Arbitration between F and K is round-robin.

Parameters:
- G_LAT, 5, cycles from the first input byte on g_inp to the first valid output byte on g_outp; legal range 1..12.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_f  in  1  F-path request; held high with data_f stable until ack_f.
- data_f  in  32  F-path G input word.
- ack_f  out  1  one-cycle pulse; result valid for F.
- req_k  in  1  key-schedule request; same rules as req_f.
- data_k  in  32  key-schedule G input word.
- ack_k  out  1  one-cycle pulse; result valid for K.
- result  out  32  G output word, registered; holds until the next ack.
- busy  out  1  high in BUSY and DONE.
- g_inp  out  8  byte to the G core.
- g_enable  out  1  G core enable.
- g_outp  in  8  byte from the G core.

Behaviour:
- Reset: all of the following are 0:
  - state = IDLE;
  - ack_f, ack_k, g_enable, busy;
  - g_inp, result, the internal shift registers, cycle counter cnt;
  - last_grant = K, so F wins the first tie.
- IDLE:
  - If exactly one request is high, grant it.
  - If both are high, grant the requester that is not last_grant.
  - On grant: latch the granted word into in_sr[31:0], record the grant, set cnt = 0, go to BUSY.
  - g_enable stays 0 while in IDLE.
- BUSY (cnt counts 0 .. G_LAT+3, one step per cycle):
  - g_enable = 1 in every BUSY cycle. It is a registered output, asserted in the cycle BUSY is entered.
  - Feed, while cnt < 4: g_inp = in_sr[7:0], then in_sr shifts right by 8. Bytes go out LSB first: byte0, byte1, byte2, byte3. g_inp = 0 once cnt >= 4.
  - Capture, while G_LAT <= cnt < G_LAT+4: g_outp shifts into the top of out_sr, i.e. out_sr <= {g_outp, out_sr[31:8]}. The first captured byte therefore ends in result[7:0].
  - Feed and capture may overlap when G_LAT < 4.
  - When cnt = G_LAT+3, go to DONE.
- DONE, exactly one cycle:
  - result <= out_sr.
  - Pulse ack of the granted port for one cycle; the ack is coincident with the new result.
  - g_enable = 0. This guarantees at least one low-enable cycle between operations, which is required to re-align the core's internal byte counter.
  - last_grant <= current grant.
  - Go to IDLE.
- Latency: request seen high in IDLE at edge T → ack at edge T+G_LAT+5. Minimum spacing between two operations is G_LAT+6 cycles, because IDLE takes one cycle.
- Request rules:
  - A request dropped before ack is a protocol violation; the operation completes regardless and the ack is still issued.
  - A request arriving while busy waits.
  - A requester re-asserting in the cycle after its ack is handled by round-robin against the other port.
- Reset mid-operation returns to IDLE immediately with all outputs 0. No ack is issued for the aborted operation.
- cnt is 4 bits wide; it never wraps within the legal G_LAT range.

Decomposition:
- Shared package (seed_pkg):
  - state encoding constants: IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  - GRANT_F = 1'b0, GRANT_K = 1'b1;
  - SEED_G_LAT default = 5.
- Optional sub-module g_rr_arbiter: a 2-way round-robin grant with a last_grant register, used only in IDLE.
- Shift registers, counter and FSM stay in the top module.

Test Plan:
All scenarios use a core model that returns input byte i as output byte i, delayed by G_LAT, so result must equal the requested word.
- Single F: req_f = 1, data_f = 0x11223344, G_LAT = 5.
  - Response: g_inp = 44, 33, 22, 11 on cnt 0..3; g_enable high for 9 cycles; ack_f 10 cycles after the request edge; result = 0x11223344; ack_k stays 0.
- Simultaneous requests out of reset: data_f = 0xAAAAAAAA, data_k = 0x55555555.
  - Response: F is served first (result 0xAAAAAAAA); then K (result 0x55555555); g_enable low for at least 1 cycle between the two.
- Fairness: both requests held high for 4 operations.
  - Response: grant order F, K, F, K; no back-to-back grants to the same port.
- G_LAT = 2 overlap: data_k = 0xDEADBEEF.
  - Response: capture starts at cnt 2 while feed is still active; result = 0xDEADBEEF; ack_k at request edge + 7.
- Reset mid-op: assert reset_n = 0 at cnt = 3, then release.
  - Response: ack_f = ack_k = 0, g_enable = 0, result = 0, busy = 0 immediately.
  - After release, a new req_k with data 0x01020304 completes normally.
- Late request: req_k rises while an F operation is busy.
  - Response: K is granted in the IDLE cycle after F's DONE; no lost request; ack_k carries K's word.
